act_engine: RTL and testbench



---
 rtl/act_engine.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_act_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_engine.sv
// Streams a vector from BRAM through a piecewise-linear sigmoid/tanh or relu and writes results back.
// Define ACT_SAT_COUNT_EN to build the saturating clamped-result counter reported in pl_status[31:16].
module act_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int BRAM_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int NUM_WORDS  = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           ps_control,
  output logic [31:0]           pl_status,
  output logic [ADDR_WIDTH-1:0] bram_addr_in,
  input  logic [BRAM_WIDTH-1:0] bram_rddata_in,
  output logic [BRAM_WIDTH-1:0] bram_wrdata_in,
  output logic [WORD_BYTES-1:0] bram_we_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [BRAM_WIDTH-1:0] bram_wrdata_out,
  output logic [WORD_BYTES-1:0] bram_we_out
);
  localparam int DW   = DATA_WIDTH;
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int CW   = 16;
  localparam int NSEG = 5;
  localparam logic signed [DW-1:0] MAX_CODE = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_CODE = {1'b1, {(DW-1){1'b0}}};

  // Table constants are given in millionths and rounded to nearest at FRAC_BITS.
  function automatic logic signed [DW-1:0] fix_u(input int micro);
    longint r;
    r = ((longint'(micro) <<< FRAC_BITS) + 64'sd500000) / 64'sd1000000;
    return r[DW-1:0];
  endfunction

  function automatic logic [DW:0] clamp(input logic signed [PW-1:0] v);
    logic [DW:0] r;
    if (v > PW'(MAX_CODE))      r = {1'b1, MAX_CODE};
    else if (v < PW'(MIN_CODE)) r = {1'b1, MIN_CODE};
    else                        r = {1'b0, v[DW-1:0]};
    return r;
  endfunction

  localparam int SIG_BOUND_U  [NSEG] = '{0, 1250000, 2250000, 3500000, 5000000};
  localparam int SIG_SLOPE_U  [NSEG] = '{221840, 127351, 52830, 15080, 0};
  localparam int SIG_ICPT_U   [NSEG] = '{500000, 618112, 785784, 917909, 1000000};
  localparam int TANH_BOUND_U [NSEG] = '{0, 750000, 1500000, 2750000, 5000000};
  localparam int TANH_SLOPE_U [NSEG] = '{846865, 359999, 69369, 3578, 0};
  localparam int TANH_ICPT_U  [NSEG] = '{0, 365150, 801094, 982021, 1000000};
  localparam logic signed [DW-1:0] ONE = fix_u(1000000);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_ERR} state_t;

  state_t                state_q, state_d;
  logic                  start;
  logic [1:0]            sel_bits;
  logic [CW-1:0]         req_count;
  logic [2:0]            mode_q;
  logic [CW-1:0]         count_q, rd_cnt_q, wr_done_q;
  logic                  rd_last;
  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_ptr_q, addr_out_q;
  logic                  d_valid_q, s1_valid_q, s2_valid_q, out_valid_q;
  logic [BRAM_WIDTH-1:0] wrdata_q;
  logic [15:0]           sat_cnt;

  logic signed [DW-1:0]  bound_sel [NSEG];
  logic signed [DW-1:0]  slope_sel [NSEG];
  logic signed [DW-1:0]  icpt_sel  [NSEG];

  logic signed [DW-1:0]  x_in, abs_x, seg_slope, seg_icpt;
  logic                  abs_sat;
  logic signed [DW-1:0]  s1_x_q, s1_abs_q, s1_slope_q, s1_icpt_q;
  logic                  s1_neg_q, s1_sat_q;

  logic signed [PW-1:0]  prod_w, prod_sh;
  logic [DW:0]           prod_c;
  logic signed [DW-1:0]  s2_x_q, s2_prod_q, s2_icpt_q;
  logic                  s2_neg_q, s2_sat_q;

  logic signed [PW-1:0]  sum_w, flip_w;
  logic [DW:0]           sum_c, flip_c;
  logic signed [DW-1:0]  y_pos, res;
  logic                  res_sat;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg_const
    assign bound_sel[gi] = mode_q[1] ? fix_u(TANH_BOUND_U[gi]) : fix_u(SIG_BOUND_U[gi]);
    assign slope_sel[gi] = mode_q[1] ? fix_u(TANH_SLOPE_U[gi]) : fix_u(SIG_SLOPE_U[gi]);
    assign icpt_sel[gi]  = mode_q[1] ? fix_u(TANH_ICPT_U[gi])  : fix_u(SIG_ICPT_U[gi]);
  end

  assign sel_bits = {1'b0, ps_control[0]} + {1'b0, ps_control[1]} + {1'b0, ps_control[2]};
  assign rd_last  = (rd_cnt_q == count_q - CW'(1));

  always_comb begin
    req_count = CW'(ps_control[15:4]);
    if (req_count == '0 || req_count > CW'(NUM_WORDS)) req_count = CW'(NUM_WORDS);
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_bits == 2'd1) begin
          state_d = ST_RUN;
          start   = 1'b1;
        end else if (sel_bits >= 2'd2) begin
          state_d = ST_ERR;
        end
      end
      ST_RUN:   if (rd_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_valid_q && wr_done_q == count_q) state_d = ST_DONE;
      ST_DONE:  if (ps_control == 32'd0) state_d = ST_IDLE;
      ST_ERR:   if (ps_control == 32'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= '0;
      count_q   <= '0;
      rd_cnt_q  <= '0;
      rd_addr_q <= '0;
      wr_ptr_q  <= '0;
      wr_done_q <= '0;
      d_valid_q <= 1'b0;
    end else begin
      d_valid_q <= (state_q == ST_RUN);
      if (start) begin
        mode_q    <= ps_control[2:0];
        count_q   <= req_count;
        rd_cnt_q  <= '0;
        rd_addr_q <= '0;
        wr_ptr_q  <= '0;
        wr_done_q <= '0;
      end else begin
        if (state_q == ST_RUN && !rd_last) begin
          rd_cnt_q  <= rd_cnt_q + CW'(1);
          rd_addr_q <= rd_addr_q + ADDR_WIDTH'(WORD_BYTES);
        end
        if (s2_valid_q) begin
          wr_ptr_q  <= wr_ptr_q + ADDR_WIDTH'(WORD_BYTES);
          wr_done_q <= wr_done_q + CW'(1);
        end
      end
    end
  end

  // Stage 1: magnitude, sign and segment lookup; the most negative code has no positive twin.
  assign x_in = $signed(bram_rddata_in[DW-1:0]);

  always_comb begin
    abs_sat = 1'b0;
    if (x_in == MIN_CODE) begin
      abs_x   = MAX_CODE;
      abs_sat = 1'b1;
    end else if (x_in[DW-1]) begin
      abs_x = -x_in;
    end else begin
      abs_x = x_in;
    end
    seg_slope = slope_sel[0];
    seg_icpt  = icpt_sel[0];
    for (int i = 1; i < NSEG; i++) begin
      if (abs_x >= bound_sel[i]) begin
        seg_slope = slope_sel[i];
        seg_icpt  = icpt_sel[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_abs_q   <= '0;
      s1_slope_q <= '0;
      s1_icpt_q  <= '0;
      s1_neg_q   <= 1'b0;
      s1_sat_q   <= 1'b0;
    end else begin
      s1_valid_q <= d_valid_q;
      s1_x_q     <= x_in;
      s1_abs_q   <= abs_x;
      s1_slope_q <= seg_slope;
      s1_icpt_q  <= seg_icpt;
      s1_neg_q   <= x_in[DW-1];
      s1_sat_q   <= abs_sat;
    end
  end

  // Stage 2: full-precision product, arithmetic shift floors toward -inf.
  assign prod_w  = PW'(s1_abs_q) * PW'(s1_slope_q);
  assign prod_sh = prod_w >>> FRAC_BITS;
  assign prod_c  = clamp(prod_sh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_prod_q  <= '0;
      s2_icpt_q  <= '0;
      s2_neg_q   <= 1'b0;
      s2_sat_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_x_q     <= s1_x_q;
      s2_prod_q  <= $signed(prod_c[DW-1:0]);
      s2_icpt_q  <= s1_icpt_q;
      s2_neg_q   <= s1_neg_q;
      s2_sat_q   <= s1_sat_q | prod_c[DW];
    end
  end

  // Stage 3: intercept, negative-side reflection, clamp.
  assign sum_w  = PW'(s2_prod_q) + PW'(s2_icpt_q);
  assign sum_c  = clamp(sum_w);
  assign y_pos  = $signed(sum_c[DW-1:0]);
  assign flip_w = mode_q[0] ? (PW'(ONE) - PW'(y_pos)) : (-PW'(y_pos));
  assign flip_c = clamp(flip_w);

  always_comb begin
    res     = y_pos;
    res_sat = s2_sat_q | sum_c[DW];
    if (mode_q[2]) begin
      res     = s2_x_q[DW-1] ? '0 : s2_x_q;
      res_sat = 1'b0;
    end else if (s2_neg_q) begin
      res     = $signed(flip_c[DW-1:0]);
      res_sat = s2_sat_q | sum_c[DW] | flip_c[DW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      addr_out_q  <= '0;
      wrdata_q    <= '0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        addr_out_q <= wr_ptr_q;
        wrdata_q   <= BRAM_WIDTH'(res);
      end
    end
  end

`ifdef ACT_SAT_COUNT_EN
  logic [15:0] sat_cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                            sat_cnt_q <= '0;
    else if (start)                                          sat_cnt_q <= '0;
    else if (s2_valid_q && res_sat && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
  end
  assign sat_cnt = sat_cnt_q;
  logic unused_ok;
  assign unused_ok = ^{ps_control[31:16], ps_control[3], bram_rddata_in};
`else
  assign sat_cnt = '0;
  logic unused_ok;
  assign unused_ok = ^{ps_control[31:16], ps_control[3], bram_rddata_in, res_sat};
`endif

  assign pl_status       = {sat_cnt, 13'd0, state_q == ST_ERR,
                            (state_q == ST_RUN) || (state_q == ST_DRAIN), state_q == ST_DONE};
  assign bram_addr_in    = rd_addr_q;
  assign bram_wrdata_in  = '0;
  assign bram_we_in      = '0;
  assign bram_addr_out   = addr_out_q;
  assign bram_wrdata_out = wrdata_q;
  assign bram_we_out     = {WORD_BYTES{out_valid_q}};

endmodule

// File: tb/tb_act_engine.sv
// Randomized bench for act_engine: BRAM model, write monitor, and a real-number reference model.
`timescale 1ns/1ps
module tb_act_engine;
  localparam int AW = 12, BW = 32, WB = 4, NW = 512, F = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   ps_control = 32'd0;
  logic [31:0]   pl_status;
  logic [AW-1:0] bram_addr_in, bram_addr_out;
  logic [BW-1:0] bram_rddata_in, bram_wrdata_in, bram_wrdata_out;
  logic [WB-1:0] bram_we_in, bram_we_out;

  always #5 clk = ~clk;

  act_engine #(.DATA_WIDTH(16), .FRAC_BITS(F), .ADDR_WIDTH(AW), .BRAM_WIDTH(BW),
               .WORD_BYTES(WB), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .ps_control(ps_control), .pl_status(pl_status),
    .bram_addr_in(bram_addr_in), .bram_rddata_in(bram_rddata_in),
    .bram_wrdata_in(bram_wrdata_in), .bram_we_in(bram_we_in),
    .bram_addr_out(bram_addr_out), .bram_wrdata_out(bram_wrdata_out), .bram_we_out(bram_we_out));

  logic [31:0] mem [1024];
  logic [31:0] rd_q;
  int          xs [NW];
  int          cyc = 0;
  always @(posedge clk) begin
    rd_q <= mem[bram_addr_in[AW-1:2]];
    cyc  <= cyc + 1;
  end
  assign bram_rddata_in = rd_q;

  typedef struct packed {logic [31:0] addr; logic [31:0] data; logic [3:0] we; int cyc;} wr_t;
  wr_t wq[$];
  always @(negedge clk)
    if (bram_we_out != '0)
      wq.push_back('{addr: 32'(bram_addr_out), data: bram_wrdata_out, we: bram_we_out, cyc: cyc});

  int n_checks = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  real bnd [2][5] = '{'{0.0, 1.25, 2.25, 3.5, 5.0}, '{0.0, 0.75, 1.5, 2.75, 5.0}};
  real slp [2][5] = '{'{0.221840, 0.127351, 0.052830, 0.015080, 0.0},
                      '{0.846865, 0.359999, 0.069369, 0.003578, 0.0}};
  real icp [2][5] = '{'{0.5, 0.618112, 0.785784, 0.917909, 1.0},
                      '{0.0, 0.365150, 0.801094, 0.982021, 1.0}};

  function automatic int fx(input real v);
    return $rtoi($floor(v * real'(1 << F) + 0.5));
  endfunction

  function automatic int sat16(input int v, output bit hit);
    hit = (v > 32767) || (v < -32768);
    if (!hit) return v;
    return (v > 0) ? 32767 : -32768;
  endfunction

  // mode: 0 sigmoid, 1 tanh, 2 relu
  function automatic int ref_act(input int mode, input int x, output bit clamped);
    int ax, seg, p, y;
    bit h;
    clamped = 1'b0;
    if (mode == 2) return (x < 0) ? 0 : x;
    ax = (x < 0) ? -x : x;
    if (ax > 32767) begin ax = 32767; clamped = 1'b1; end
    seg = 0;
    for (int i = 1; i < 5; i++) if (ax >= fx(bnd[mode][i])) seg = i;
    p = sat16((fx(slp[mode][seg]) * ax) >>> F, h);          clamped = clamped | h;
    y = sat16(p + fx(icp[mode][seg]), h);                   clamped = clamped | h;
    if (x < 0) begin
      y = sat16((mode == 0) ? fx(1.0) - y : -y, h);         clamped = clamped | h;
    end
    return y;
  endfunction

  function automatic int pick_x();
    int sp [17] = '{0, -32768, 32767, -1, 1, 1280, 1279, -1280, 2304, 3584,
                    5120, 5119, -5120, 768, 1536, 2816, -2816};
    logic signed [15:0] t;
    case ($urandom_range(0, 2))
      0:       return sp[$urandom_range(0, 16)];
      1:       return int'($urandom_range(0, 12287)) - 6144;
      default: begin t = 16'($urandom); return int'(t); end
    endcase
  endfunction

  task automatic load_x(input int k, input int x);
    xs[k]  = x;
    mem[k] = {16'($urandom), 16'(x)};
  endtask

  task automatic do_run(input int mode, input int nfield, input bit poke);
    int n, start_cyc, w, exp_v, nsat;
    bit s;
    logic [31:0] exp_stat;
    n = (nfield == 0) ? NW : nfield;
    nsat = 0;
    wq.delete();
    @(negedge clk);
    ps_control = (32'(nfield) << 4) | (32'd1 << mode);
    @(posedge clk); #1;
    start_cyc = cyc;
    chk("busy", 32'(pl_status[1]), 32'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      ps_control = $urandom | 32'd7;
    end
    w = 0;
    while (pl_status[0] !== 1'b1 && w < n + 40) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 32'(pl_status[0]), 32'd1);
    chk("done_cycle", 32'(cyc), 32'(start_cyc + n + 4));
    chk("n_writes", 32'(wq.size()), 32'(n));
    for (int k = 0; k < n && k < wq.size(); k++) begin
      exp_v = ref_act(mode, xs[k], s);
      if (s) nsat++;
      chk("wr_addr", wq[k].addr, 32'(k * WB));
      chk("wr_data", wq[k].data, 32'(exp_v));
      chk("wr_we", 32'(wq[k].we), 32'hF);
      chk("wr_cycle", 32'(wq[k].cyc), 32'(start_cyc + 4 + k));
    end
`ifdef ACT_SAT_COUNT_EN
    exp_stat = {16'((nsat > 65535) ? 65535 : nsat), 16'd1};
`else
    exp_stat = 32'd1;
`endif
    chk("status_done", pl_status, exp_stat);
    ps_control = 32'd0;
    @(negedge clk);
    chk("status_idle", pl_status, 32'd0);
    $display("run mode=%0d count=%0d writes=%0d sat=%0d", mode, n, wq.size(), nsat);
  endtask

  initial begin
    int nb, w;
    repeat (3) @(negedge clk);
    chk("rst_status", pl_status, 32'd0);
    chk("rst_we", 32'(bram_we_out), 32'd0);
    chk("rst_addr_in", 32'(bram_addr_in), 32'd0);
    chk("rst_addr_out", 32'(bram_addr_out), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Only ignored bits set: must stay idle.
    ps_control = 32'hFFFF_0008;
    repeat (3) @(negedge clk);
    chk("idle_ignore", pl_status, 32'd0);
    ps_control = 32'd0;

    load_x(0, 0); load_x(1, 1024); load_x(2, -1024); load_x(3, 6144);
    do_run(0, 4, 1'b0);

    load_x(0, -32768); load_x(1, 32767); load_x(2, -1);
    do_run(2, 3, 1'b0);

    foreach (xs[i]) ;
    for (int e = 0; e < 3; e++) begin
      wq.delete();
      @(negedge clk);
      ps_control = (e == 0) ? 32'h3 : (e == 1) ? 32'h5 : 32'h7;
      repeat (2) @(negedge clk);
      chk("err_status", pl_status, 32'h4);
      repeat (4) @(negedge clk);
      chk("err_hold", pl_status, 32'h4);
      chk("err_no_writes", 32'(wq.size()), 32'd0);
      ps_control = 32'd0;
      @(negedge clk);
      chk("err_exit", pl_status, 32'd0);
      $display("err ctrl=%0d writes=%0d", e, wq.size());
    end

    for (int k = 0; k < NW / 2; k++) begin
      int x;
      x = pick_x();
      if (x == -32768) x = -32767;
      load_x(2 * k, x);
      load_x(2 * k + 1, -x);
    end
    do_run(1, 0, 1'b1);
    if (wq.size() == NW) begin
      chk("tanh_last_addr", wq[NW-1].addr, 32'h7FC);
      for (int k = 0; k < NW; k += 64)
        chk("tanh_odd", wq[k + 1].data, -wq[k].data);
    end

    for (int r = 0; r < 8; r++) begin
      int m, nf;
      m  = $urandom_range(0, 2);
      nf = $urandom_range(1, 48);
      for (int k = 0; k < nf; k++) load_x(k, pick_x());
      do_run(m, nf, 1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < NW; k++) load_x(k, pick_x());
    wq.delete();
    @(negedge clk);
    ps_control = 32'h2;
    w = 0;
    while (wq.size() < 100 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("rst_reach100", 32'(wq.size() >= 100), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(bram_we_out), 32'd0);
    chk("rst_mid_status", pl_status, 32'd0);
    ps_control = 32'd0;
    nb = wq.size();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_writes", 32'(wq.size()), 32'(nb));
    chk("rst_idle", pl_status, 32'd0);
    $display("reset mid-run writes_before=%0d", nb);

    for (int k = 0; k < 8; k++) load_x(k, pick_x());
    do_run(0, 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end
endmodule
